computie_bus_capture: RTL and testbench

COMPUTIE_BUS_CAPTURE -- requirements
Module: computie_bus_capture

---
 rtl/computie_bus_pkg.sv | 47 ++++
 rtl/computie_bus_cycle_tracker.sv | 83 ++++++++
 rtl/computie_bus_capture.sv | 227 ++++++++++++++++++++++
 tb/tb_computie_bus_capture.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/computie_bus_pkg.sv
// rtl/computie_bus_pkg.sv - shared constants and encodings for the computie bus capture block
//
// Contents:
//   STROBE_ACTIVE / STROBE_INACTIVE : levels of the active-low bus strobes
//   cap_state_t                     : capture FSM encoding
//   trk_state_t                     : bus cycle tracker encoding
//   rec_* functions                 : bit offsets of the fields in a stored record
//                                     {trig_mark, rw, addr, data}, data in the LSBs

package computie_bus_pkg;

    localparam logic STROBE_ACTIVE   = 1'b0;
    localparam logic STROBE_INACTIVE = 1'b1;

    typedef enum logic [2:0] {
        CAP_IDLE    = 3'd0,
        CAP_ARMED   = 3'd1,
        CAP_POST    = 3'd2,
        CAP_DONE    = 3'd3,
        CAP_READOUT = 3'd4
    } cap_state_t;

    typedef enum logic [1:0] {
        TRK_WAIT_AS  = 2'd0,
        TRK_WAIT_DS  = 2'd1,
        TRK_WAIT_END = 2'd2
    } trk_state_t;

    localparam int REC_DATA_LSB = 0;

    function automatic int rec_addr_lsb(input int data_width);
        return data_width;
    endfunction

    function automatic int rec_rw_bit(input int addr_width, input int data_width);
        return addr_width + data_width;
    endfunction

    function automatic int rec_mark_bit(input int addr_width, input int data_width);
        return addr_width + data_width + 1;
    endfunction

    function automatic int rec_width(input int addr_width, input int data_width);
        return addr_width + data_width + 2;
    endfunction

endpackage

// File: rtl/computie_bus_cycle_tracker.sv
// rtl/computie_bus_cycle_tracker.sv - follows one multiplexed bus cycle and reports its completion
//
// Ports:
//   cb_clk, cb_reset         : clock, synchronous active-high reset
//   enable                   : tracker runs only while high; otherwise it idles in WAIT_AS
//   cb_addr_strobe           : address strobe, active-low
//   cb_data_strobe           : data strobe, active-low
//   cb_read_write            : bus direction, 1 = read
//   cb_addr_data_bus         : multiplexed address/data bus
//   addr_oe, data_oe         : transceiver enables, active-low
//   cycle_done               : one-cycle strobe, a bus cycle has completed
//   cycle_rw/addr/data       : fields of the completed cycle, valid with cycle_done

module computie_bus_cycle_tracker #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 32
) (
    input  logic                  cb_clk,
    input  logic                  cb_reset,
    input  logic                  enable,
    input  logic                  cb_addr_strobe,
    input  logic                  cb_data_strobe,
    input  logic                  cb_read_write,
    input  logic [BUS_WIDTH-1:0]  cb_addr_data_bus,
    output logic                  addr_oe,
    output logic                  data_oe,
    output logic                  cycle_done,
    output logic                  cycle_rw,
    output logic [ADDR_WIDTH-1:0] cycle_addr,
    output logic [DATA_WIDTH-1:0] cycle_data
);

    import computie_bus_pkg::*;

    trk_state_t state;

    always_ff @(posedge cb_clk) begin
        if (cb_reset || !enable) begin
            state      <= TRK_WAIT_AS;
            addr_oe    <= 1'b1;
            data_oe    <= 1'b1;
            cycle_done <= 1'b0;
            cycle_rw   <= 1'b0;
            cycle_addr <= '0;
            cycle_data <= '0;
        end else begin
            cycle_done <= 1'b0;
            case (state)
                TRK_WAIT_AS: begin
                    if (cb_addr_strobe == STROBE_ACTIVE) begin
                        cycle_addr <= cb_addr_data_bus[ADDR_WIDTH-1:0];
                        cycle_rw   <= cb_read_write;
                        addr_oe    <= 1'b0;
                        state      <= TRK_WAIT_DS;
                    end
                end
                TRK_WAIT_DS: begin
                    if (cb_data_strobe == STROBE_ACTIVE) begin
                        addr_oe <= 1'b1;
                        data_oe <= 1'b0;
                        state   <= TRK_WAIT_END;
                    end
                end
                TRK_WAIT_END: begin
                    // Data is taken on the edge that sees DS released.
                    if (cb_data_strobe == STROBE_INACTIVE) begin
                        cycle_data <= cb_addr_data_bus[DATA_WIDTH-1:0];
                        cycle_done <= 1'b1;
                        data_oe    <= 1'b1;
                        state      <= TRK_WAIT_AS;
                    end
                end
                default: begin
                    state   <= TRK_WAIT_AS;
                    addr_oe <= 1'b1;
                    data_oe <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/computie_bus_capture.sv
// rtl/computie_bus_capture.sv - triggered ring-buffer capture of bus cycles with streamed readout
//
// Ports:
//   cb_clk, cb_reset                    : clock, synchronous active-high reset
//   cb_addr_strobe, cb_data_strobe      : bus strobes, active-low
//   cb_read_write                       : bus direction, 1 = read
//   cb_addr_data_bus                    : multiplexed address/data bus
//   addr_oe, data_oe                    : transceiver enables, active-low
//   send_receive, data_dir              : constant 0, receive only
//   record_start                        : arm request (honoured in IDLE)
//   record_trigger                      : manual trigger (honoured in ARMED)
//   trig_addr, trig_mask                : address trigger, mask bit 1 = compare
//   trig_rw_en, trig_rw                 : optional direction qualifier for the trigger
//   post_count                          : cycles stored from the trigger on (0 acts as 1)
//   record_valid/ready/out              : readout stream {trig_mark, rw, addr, data}
//   record_end                          : one-cycle pulse after the last entry is accepted
//   state_led                           : high in DONE and READOUT

module computie_bus_capture #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64
) (
    input  logic                                    cb_clk,
    input  logic                                    cb_reset,
    input  logic                                    cb_addr_strobe,
    input  logic                                    cb_data_strobe,
    input  logic                                    cb_read_write,
    input  logic [((ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH)-1:0] cb_addr_data_bus,
    output logic                                    addr_oe,
    output logic                                    data_oe,
    output logic                                    send_receive,
    output logic                                    data_dir,
    input  logic                                    record_start,
    input  logic                                    record_trigger,
    input  logic [ADDR_WIDTH-1:0]                   trig_addr,
    input  logic [ADDR_WIDTH-1:0]                   trig_mask,
    input  logic                                    trig_rw_en,
    input  logic                                    trig_rw,
    input  logic [$clog2(DEPTH):0]                  post_count,
    output logic                                    record_valid,
    input  logic                                    record_ready,
    output logic [ADDR_WIDTH+DATA_WIDTH+1:0]        record_out,
    output logic                                    record_end,
    output logic                                    state_led
);

    import computie_bus_pkg::*;

    localparam int BUS_WIDTH    = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int PTR_W        = $clog2(DEPTH);
    localparam int CNT_W        = PTR_W + 1;
    localparam int REC_W        = rec_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int REC_ADDR_LSB = rec_addr_lsb(DATA_WIDTH);
    localparam int REC_RW       = rec_rw_bit(ADDR_WIDTH, DATA_WIDTH);
    localparam int REC_MARK     = rec_mark_bit(ADDR_WIDTH, DATA_WIDTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

    cap_state_t              state;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        fill;
    logic [CNT_W-1:0]        remaining;
    logic [CNT_W-1:0]        rd_left;
    logic                    trig_pending;
    logic [REC_W-1:0]        mem [DEPTH];

    logic                    trk_en;
    logic                    cmp_done;
    logic                    cmp_rw;
    logic [ADDR_WIDTH-1:0]   cmp_addr;
    logic [DATA_WIDTH-1:0]   cmp_data;
    logic                    addr_hit;
    logic                    trig_now;
    logic                    wr_en;
    logic                    wr_mark;
    logic [REC_W-1:0]        wr_rec;
    logic [CNT_W-1:0]        post_eff;
    logic [PTR_W-1:0]        oldest_ptr;

    assign send_receive = 1'b0;
    assign data_dir     = 1'b0;

    computie_bus_cycle_tracker #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .BUS_WIDTH  (BUS_WIDTH)
    ) u_tracker (
        .cb_clk           (cb_clk),
        .cb_reset         (cb_reset),
        .enable           (trk_en),
        .cb_addr_strobe   (cb_addr_strobe),
        .cb_data_strobe   (cb_data_strobe),
        .cb_read_write    (cb_read_write),
        .cb_addr_data_bus (cb_addr_data_bus),
        .addr_oe          (addr_oe),
        .data_oe          (data_oe),
        .cycle_done       (cmp_done),
        .cycle_rw         (cmp_rw),
        .cycle_addr       (cmp_addr),
        .cycle_data       (cmp_data)
    );

    always_comb begin
        trk_en     = (state == CAP_ARMED) || (state == CAP_POST);
        addr_hit   = (((cmp_addr ^ trig_addr) & trig_mask) == '0) &&
                     (!trig_rw_en || (cmp_rw == trig_rw));
        // A manual trigger landing on a completion marks that completion.
        trig_now   = (state == CAP_ARMED) && cmp_done && (addr_hit || record_trigger);
        wr_en      = cmp_done && trk_en;
        wr_mark    = trig_now || ((state == CAP_POST) && trig_pending);
        post_eff   = (post_count == '0) ? ONE_CNT : post_count;
        // Wraps naturally: with a full buffer fill[PTR_W-1:0] is 0 and the
        // oldest entry is the one about to be overwritten next.
        oldest_ptr = wr_ptr - fill[PTR_W-1:0];

        wr_rec                               = '0;
        wr_rec[REC_MARK]                     = wr_mark;
        wr_rec[REC_RW]                       = cmp_rw;
        wr_rec[REC_ADDR_LSB +: ADDR_WIDTH]   = cmp_addr;
        wr_rec[REC_DATA_LSB +: DATA_WIDTH]   = cmp_data;
    end

    always_ff @(posedge cb_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_rec;
        end
    end

    always_ff @(posedge cb_clk) begin
        if (cb_reset) begin
            state        <= CAP_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill         <= '0;
            remaining    <= '0;
            rd_left      <= '0;
            trig_pending <= 1'b0;
            record_valid <= 1'b0;
            record_end   <= 1'b0;
            state_led    <= 1'b0;
            record_out   <= '0;
        end else begin
            record_end <= 1'b0;

            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (fill != DEPTH_CNT) begin
                    fill <= fill + ONE_CNT;
                end
            end

            case (state)
                CAP_IDLE: begin
                    if (record_start) begin
                        state        <= CAP_ARMED;
                        wr_ptr       <= '0;
                        fill         <= '0;
                        trig_pending <= 1'b0;
                    end
                end
                CAP_ARMED: begin
                    if (trig_now) begin
                        // The trigger completion itself uses up one post slot.
                        if (post_eff == ONE_CNT) begin
                            state     <= CAP_DONE;
                            state_led <= 1'b1;
                        end else begin
                            state     <= CAP_POST;
                            remaining <= post_eff - ONE_CNT;
                        end
                    end else if (record_trigger) begin
                        state        <= CAP_POST;
                        remaining    <= post_eff;
                        trig_pending <= 1'b1;
                    end
                end
                CAP_POST: begin
                    if (cmp_done) begin
                        trig_pending <= 1'b0;
                        if (remaining == ONE_CNT) begin
                            state     <= CAP_DONE;
                            state_led <= 1'b1;
                        end else begin
                            remaining <= remaining - ONE_CNT;
                        end
                    end
                end
                CAP_DONE: begin
                    if (fill == '0) begin
                        record_end <= 1'b1;
                        state_led  <= 1'b0;
                        state      <= CAP_IDLE;
                    end else begin
                        // Prefetch the oldest entry so valid rises on entry to READOUT.
                        record_out   <= mem[oldest_ptr];
                        rd_ptr       <= oldest_ptr + 1'b1;
                        rd_left      <= fill;
                        record_valid <= 1'b1;
                        state        <= CAP_READOUT;
                    end
                end
                CAP_READOUT: begin
                    if (record_valid && record_ready) begin
                        if (rd_left == ONE_CNT) begin
                            record_valid <= 1'b0;
                            record_end   <= 1'b1;
                            state_led    <= 1'b0;
                            state        <= CAP_IDLE;
                        end else begin
                            record_out <= mem[rd_ptr];
                            rd_ptr     <= rd_ptr + 1'b1;
                            rd_left    <= rd_left - ONE_CNT;
                        end
                    end
                end
                default: begin
                    state        <= CAP_IDLE;
                    record_valid <= 1'b0;
                    state_led    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_computie_bus_capture.sv
// tb/tb_computie_bus_capture.sv - directed self-checking bench for computie_bus_capture

module tb_computie_bus_capture;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int REC_W = AW + DW + 2;

    logic              cb_clk = 1'b0;
    logic              cb_reset;
    logic              cb_addr_strobe;
    logic              cb_data_strobe;
    logic              cb_read_write;
    logic [31:0]       cb_addr_data_bus;
    logic              addr_oe;
    logic              data_oe;
    logic              send_receive;
    logic              data_dir;
    logic              record_start;
    logic              record_trigger;
    logic [AW-1:0]     trig_addr;
    logic [AW-1:0]     trig_mask;
    logic              trig_rw_en;
    logic              trig_rw;
    logic [3:0]        post_count;
    logic              record_valid;
    logic              record_ready;
    logic [REC_W-1:0]  record_out;
    logic              record_end;
    logic              state_led;

    int checks = 0;
    int errors = 0;
    bit chk_oe = 0;
    logic [REC_W-1:0] exp_q[$];
    logic [REC_W-1:0] got_q[$];

    always #5 cb_clk = ~cb_clk;

    computie_bus_capture #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .cb_clk           (cb_clk),
        .cb_reset         (cb_reset),
        .cb_addr_strobe   (cb_addr_strobe),
        .cb_data_strobe   (cb_data_strobe),
        .cb_read_write    (cb_read_write),
        .cb_addr_data_bus (cb_addr_data_bus),
        .addr_oe          (addr_oe),
        .data_oe          (data_oe),
        .send_receive     (send_receive),
        .data_dir         (data_dir),
        .record_start     (record_start),
        .record_trigger   (record_trigger),
        .trig_addr        (trig_addr),
        .trig_mask        (trig_mask),
        .trig_rw_en       (trig_rw_en),
        .trig_rw          (trig_rw),
        .post_count       (post_count),
        .record_valid     (record_valid),
        .record_ready     (record_ready),
        .record_out       (record_out),
        .record_end       (record_end),
        .state_led        (state_led)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [REC_W-1:0] mk(input bit mark, input bit rw,
                                            input logic [31:0] a, input logic [31:0] d);
        return {mark, rw, a, d};
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge cb_clk);
    endtask

    task automatic arm();
        @(negedge cb_clk); record_start = 1'b1;
        @(negedge cb_clk); record_start = 1'b0;
    endtask

    task automatic manual_trigger();
        @(negedge cb_clk); record_trigger = 1'b1;
        @(negedge cb_clk); record_trigger = 1'b0;
    endtask

    // One bus cycle; with trig_with the manual trigger coincides with the completion strobe.
    task automatic bus_cycle(input bit rw, input logic [31:0] a, input logic [31:0] d,
                             input bit trig_with);
        @(negedge cb_clk);
        cb_addr_data_bus = a; cb_read_write = rw; cb_addr_strobe = 1'b0;
        @(negedge cb_clk);
        cb_data_strobe = 1'b0;
        if (chk_oe) check("addr_oe_in_wait_ds", addr_oe, 0);
        @(negedge cb_clk);
        cb_addr_data_bus = d;
        if (chk_oe) check("data_oe_in_wait_end", data_oe, 0);
        @(negedge cb_clk);
        cb_data_strobe = 1'b1; cb_addr_strobe = 1'b1;
        @(negedge cb_clk);
        if (trig_with) record_trigger = 1'b1;
        @(negedge cb_clk);
        record_trigger = 1'b0;
    endtask

    task automatic do_readout(input string tag, input bit toggle);
        int cyc = 0;
        bit seen_end = 0;
        bit rdy;
        bit prev_stall = 0;
        logic [REC_W-1:0] prev_out = '0;
        got_q.delete();
        while (!seen_end && cyc < 300) begin
            @(negedge cb_clk);
            cyc++;
            if (prev_stall) begin
                check({tag, "_stall_valid"}, record_valid, 1);
                check({tag, "_stall_hold"}, record_out, prev_out);
            end
            if (record_end) begin
                seen_end = 1;
                check({tag, "_valid_low_at_end"}, record_valid, 0);
            end else begin
                rdy = toggle ? (cyc % 2 == 1) : 1'b1;
                record_ready = rdy;
                if (record_valid && rdy) got_q.push_back(record_out);
                prev_stall = record_valid && !rdy;
                prev_out   = record_out;
            end
        end
        record_ready = 1'b0;
        check({tag, "_end_seen"}, seen_end, 1);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_rec%0d", tag, i), got_q[i], exp_q[i]);
        @(negedge cb_clk);
        check({tag, "_end_one_cycle"}, record_end, 0);
        check({tag, "_led_off"}, state_led, 0);
    endtask

    initial begin
        int marks;
        cb_reset = 1'b1; cb_addr_strobe = 1'b1; cb_data_strobe = 1'b1; cb_read_write = 1'b0;
        cb_addr_data_bus = '0; record_start = 1'b0; record_trigger = 1'b0;
        trig_addr = 32'hDEAD_0000; trig_mask = 32'hFFFF_FFFF; trig_rw_en = 1'b0; trig_rw = 1'b0;
        post_count = 4'd2; record_ready = 1'b0;
        tick(3);
        cb_reset = 1'b0;
        @(negedge cb_clk);
        check("rst_valid", record_valid, 0);
        check("rst_end", record_end, 0);
        check("rst_led", state_led, 0);
        check("rst_addr_oe", addr_oe, 1);
        check("rst_data_oe", data_oe, 1);
        check("send_receive", send_receive, 0);
        check("data_dir", data_dir, 0);

        // Three writes, manual trigger, two post writes.
        arm();
        chk_oe = 1;
        bus_cycle(1'b0, 32'h100, 32'h11, 1'b0);
        chk_oe = 0;
        bus_cycle(1'b0, 32'h104, 32'h22, 1'b0);
        bus_cycle(1'b0, 32'h108, 32'h33, 1'b0);
        manual_trigger();
        arm();
        bus_cycle(1'b0, 32'h10C, 32'h44, 1'b0);
        bus_cycle(1'b0, 32'h110, 32'h55, 1'b0);
        tick(2);
        check("s1_led_readout", state_led, 1);
        check("s1_valid_up", record_valid, 1);
        exp_q = '{mk(0,0,32'h100,32'h11), mk(0,0,32'h104,32'h22), mk(0,0,32'h108,32'h33),
                  mk(1,0,32'h10C,32'h44), mk(0,0,32'h110,32'h55)};
        do_readout("s1", 1'b0);

        // Wrapped history, masked address trigger, stalled readout.
        trig_addr = 32'h2000; trig_mask = 32'hFFFF_F000; post_count = 4'd1;
        arm();
        for (int i = 0; i < 20; i++) bus_cycle(1'b1, 32'h1000 + 4 * i, i, 1'b0);
        bus_cycle(1'b1, 32'h2ABC, 32'hABC0, 1'b0);
        exp_q.delete();
        for (int i = 13; i < 20; i++) exp_q.push_back(mk(0, 1, 32'h1000 + 4 * i, i));
        exp_q.push_back(mk(1, 1, 32'h2ABC, 32'hABC0));
        do_readout("s2", 1'b1);

        // Direction-qualified trigger, post_count 0 acts as 1.
        trig_addr = 32'h300; trig_mask = 32'hFFFF_FFFF; trig_rw_en = 1'b1; trig_rw = 1'b0;
        post_count = 4'd0;
        arm();
        bus_cycle(1'b1, 32'h300, 32'hA1, 1'b0);
        bus_cycle(1'b0, 32'h400, 32'hA2, 1'b0);
        tick(2);
        check("s3_no_trig_on_read", state_led, 0);
        bus_cycle(1'b0, 32'h300, 32'hA3, 1'b0);
        exp_q = '{mk(0,1,32'h300,32'hA1), mk(0,0,32'h400,32'hA2), mk(1,0,32'h300,32'hA3)};
        do_readout("s3", 1'b0);

        // Reset in POST, then rearm with a coincident trigger.
        trig_addr = 32'hDEAD_0000; trig_rw_en = 1'b0; post_count = 4'd5;
        arm();
        bus_cycle(1'b0, 32'h500, 32'h5, 1'b0);
        manual_trigger();
        bus_cycle(1'b0, 32'h504, 32'h6, 1'b0);
        @(negedge cb_clk); cb_reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge cb_clk);
            check("s4_no_end_in_reset", record_end, 0);
        end
        cb_reset = 1'b0;
        @(negedge cb_clk);
        check("s4_rst_valid", record_valid, 0);
        check("s4_rst_end", record_end, 0);
        check("s4_rst_led", state_led, 0);
        check("s4_rst_addr_oe", addr_oe, 1);
        check("s4_rst_data_oe", data_oe, 1);
        post_count = 4'd2;
        arm();
        bus_cycle(1'b0, 32'h600, 32'h66, 1'b0);
        bus_cycle(1'b0, 32'h604, 32'h77, 1'b1);
        bus_cycle(1'b0, 32'h608, 32'h88, 1'b0);
        exp_q = '{mk(0,0,32'h600,32'h66), mk(1,0,32'h604,32'h77), mk(0,0,32'h608,32'h88)};
        do_readout("s4", 1'b0);
        marks = 0;
        foreach (got_q[i]) if (got_q[i][REC_W-1]) marks++;
        check("s4_one_mark", marks, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
